uart_loader_ctrl: RTL and testbench

Command sequencer that owns the host-facing UART's FIFO interface (rd_uart/rx_empty/r_data, wr_uart/tx_full/w_data) and drives the MIPS debug plane.
Decodes single-byte host commands to load instruction memory, run, halt or step the CPU, and dump one 32-bit debug word.
Sits between the UART instance and the CPU/instruction-memory top level; it is the only master of both UART FIFOs.

---
 rtl/uart_loader_ctrl_pkg.sv | 38 +++
 rtl/uart_loader_ctrl_tx_byte_seq.sv | 51 +++++
 rtl/uart_loader_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_loader_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART loader/debug controller:
//   - host command bytes ('L','R','H','S','D')
//   - reply codes sent back to the host (ACK, NAK, HALTED)
//   - controller state encoding (also exported on the dbg_state port)
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_HALT = 8'h48;  // 'H'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'

  // Reply codes
  localparam logic [7:0] CODE_ACK    = 8'h06;
  localparam logic [7:0] CODE_NAK    = 8'h15;
  localparam logic [7:0] CODE_HALTED = 8'h68;  // 'h': CPU stopped on its own

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_N     = 3'd1,
    ST_GET_B     = 3'd2,
    ST_WRITE     = 3'd3,
    ST_GET_IDX   = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_SEND      = 3'd6,
    ST_RUN       = 3'd7
  } state_t;

  // Pack a single reply byte into the serializer's 32-bit load word.
  function automatic logic [31:0] one_byte(input logic [7:0] b);
    return {24'h000000, b};
  endfunction

endpackage

// File: rtl/uart_loader_ctrl_tx_byte_seq.sv
// -----------------------------------------------------------------------------
// tx_byte_seq
// Serializes 1..4 bytes (LSB first) into the UART TX FIFO under backpressure.
//   clk, reset   : clock, asynchronous active-high reset
//   i_load       : load i_bytes/i_count (only issued while idle)
//   i_bytes      : bytes to send, byte 0 in [7:0]
//   i_count      : number of bytes to send (1..4)
//   i_tx_full    : TX FIFO full; a pending byte waits while high
//   o_w_data     : byte presented to the TX FIFO
//   o_wr_uart    : TX push strobe (only while i_tx_full=0)
//   o_busy       : bytes still pending
//   o_done       : high in the cycle of the last push
// Handshake: a byte is transferred in every cycle where o_wr_uart=1, i.e.
// a byte is pending and i_tx_full=0; o_w_data is stable throughout that cycle.
// -----------------------------------------------------------------------------
module tx_byte_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_bytes,
  input  logic [2:0]  i_count,
  input  logic        i_tx_full,
  output logic [7:0]  o_w_data,
  output logic        o_wr_uart,
  output logic        o_busy,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [2:0]  r_left;

  assign o_busy    = (r_left != 3'd0);
  assign o_wr_uart = o_busy & ~i_tx_full;
  assign o_w_data  = r_shift[7:0];
  assign o_done    = o_wr_uart & (r_left == 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= 32'h0;
      r_left  <= 3'd0;
    end else if (i_load) begin
      r_shift <= i_bytes;
      r_left  <= i_count;
    end else if (o_wr_uart) begin
      // Zero-fill keeps w_data at 0 once the sequence has drained.
      r_shift <= {8'h00, r_shift[31:8]};
      r_left  <= r_left - 3'd1;
    end
  end

endmodule

// File: rtl/uart_loader_ctrl.sv
// -----------------------------------------------------------------------------
// uart_loader_ctrl
// Host command sequencer: sole master of the UART RX/TX FIFOs, loads the
// instruction memory, runs/halts/steps the CPU and dumps one debug word.
//
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   rx_empty, r_data       : RX FIFO status / head byte
//   rd_uart                : RX pop strobe (same cycle r_data is consumed)
//   tx_full, w_data        : TX FIFO status / byte to push
//   wr_uart                : TX push strobe
//   imem_we/addr/wdata     : instruction-memory write port
//   cpu_run                : CPU free-run enable (level)
//   cpu_step               : one-cycle CPU advance pulse
//   cpu_halted             : CPU reached a HALT instruction
//   dbg_sel, dbg_data      : debug word selector / returned word
//   dbg_state              : current controller state (state_t encoding)
//
// Handshakes: RX byte is consumed in a cycle where rd_uart=1 (only when
// rx_empty=0); TX byte is transferred in a cycle where wr_uart=1 (only when
// tx_full=0). Both are at most one transfer per cycle.
//
// Optional build macro UART_CTRL_TIMEOUT_EN: inter-byte timeout of
// TIMEOUT_CYC cycles while waiting for load/dump argument bytes; on expiry
// the command is aborted with NAK.
// -----------------------------------------------------------------------------
module uart_loader_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 6_400_000,
  parameter int TO_W        = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              cpu_step,
  input  logic              cpu_halted,
  output logic [7:0]        dbg_sel,
  input  logic [31:0]       dbg_data,
  output logic [2:0]        dbg_state
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_word;
  logic [1:0]        r_byte_idx;
  logic [8:0]        r_count;     // words to load, 1..256
  logic [8:0]        r_word_cnt;  // words written so far
  logic              r_cpu_run;
  logic              r_cpu_step;
  logic [7:0]        r_dbg_sel;

  logic              w_rx_ok;
  logic              w_pop;
  logic              w_tx_load;
  logic [31:0]       w_tx_bytes;
  logic [2:0]        w_tx_cnt;
  logic              w_tx_busy;
  logic              w_tx_done;
  logic              w_timeout;

  assign w_rx_ok = ~rx_empty;

  // ---------------------------------------------------------------------------
  // Inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef UART_CTRL_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            w_waiting;

  assign w_waiting = (r_state == ST_GET_N) || (r_state == ST_GET_B) ||
                     (r_state == ST_GET_IDX);
  // Counter restarts on entry to a waiting state and on every pop.
  assign w_timeout = w_waiting & ~w_rx_ok &
                     (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (!w_waiting || w_pop) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_to;
  assign w_timeout   = 1'b0;
  assign w_unused_to = (TIMEOUT_CYC == 0) ^ (TO_W == 0);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, RX pop and reply load
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_tx_load  = 1'b0;
    w_tx_bytes = 32'h0;
    w_tx_cnt   = 3'd0;

    case (r_state)
      ST_IDLE: begin
        if (w_rx_ok) begin
          w_pop = 1'b1;
          case (r_data)
            CMD_LOAD: w_next = ST_GET_N;
            CMD_RUN:  w_next = ST_RUN;
            CMD_DUMP: w_next = ST_GET_IDX;
            CMD_HALT, CMD_STEP: begin
              w_tx_load  = 1'b1;
              w_tx_bytes = one_byte(CODE_ACK);
              w_tx_cnt   = 3'd1;
              w_next     = ST_SEND;
            end
            default: begin
              w_tx_load  = 1'b1;
              w_tx_bytes = one_byte(CODE_NAK);
              w_tx_cnt   = 3'd1;
              w_next     = ST_SEND;
            end
          endcase
        end
      end

      ST_GET_N, ST_GET_B, ST_GET_IDX: begin
        if (w_rx_ok) begin
          w_pop = 1'b1;
          if (r_state == ST_GET_N) begin
            w_next = ST_GET_B;
          end else if (r_state == ST_GET_IDX) begin
            w_next = ST_DUMP_WAIT;
          end else if (r_byte_idx == 2'd3) begin
            w_next = ST_WRITE;
          end
        end else if (w_timeout) begin
          w_tx_load  = 1'b1;
          w_tx_bytes = one_byte(CODE_NAK);
          w_tx_cnt   = 3'd1;
          w_next     = ST_SEND;
        end
      end

      ST_WRITE: begin
        if (r_word_cnt + 9'd1 == r_count) begin
          w_tx_load  = 1'b1;
          w_tx_bytes = one_byte(CODE_ACK);
          w_tx_cnt   = 3'd1;
          w_next     = ST_SEND;
        end else begin
          w_next = ST_GET_B;
        end
      end

      ST_DUMP_WAIT: begin
        // dbg_sel changed on entry; dbg_data has settled by the end of this cycle.
        w_tx_load  = 1'b1;
        w_tx_bytes = dbg_data;
        w_tx_cnt   = 3'd4;
        w_next     = ST_SEND;
      end

      ST_SEND: begin
        if (w_tx_done) begin
          w_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        // A CPU halt takes priority over a host byte in the same cycle.
        if (cpu_halted) begin
          w_tx_load  = 1'b1;
          w_tx_bytes = one_byte(CODE_HALTED);
          w_tx_cnt   = 3'd1;
          w_next     = ST_SEND;
        end else if (w_rx_ok) begin
          w_pop = 1'b1;
          if (r_data == CMD_HALT) begin
            w_tx_load  = 1'b1;
            w_tx_bytes = one_byte(CODE_ACK);
            w_tx_cnt   = 3'd1;
            w_next     = ST_SEND;
          end
        end
      end

      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_word     <= 32'h0;
      r_byte_idx <= 2'd0;
      r_count    <= 9'd0;
      r_word_cnt <= 9'd0;
      r_cpu_run  <= 1'b0;
      r_cpu_step <= 1'b0;
      r_dbg_sel  <= 8'h00;
    end else begin
      if (w_pop && r_state == ST_GET_N) begin
        r_count    <= (r_data == 8'h00) ? 9'd256 : {1'b0, r_data};
        r_addr     <= '0;
        r_word_cnt <= 9'd0;
        r_byte_idx <= 2'd0;
      end

      // Little-endian assembly: each new byte enters at the top.
      if (w_pop && r_state == ST_GET_B) begin
        r_word     <= {r_data, r_word[31:8]};
        r_byte_idx <= r_byte_idx + 2'd1;
      end

      // Address wraps naturally at 2^ADDR_W.
      if (r_state == ST_WRITE) begin
        r_addr     <= r_addr + 1'b1;
        r_word_cnt <= r_word_cnt + 9'd1;
      end

      if (w_pop && r_state == ST_GET_IDX) begin
        r_dbg_sel <= r_data;
      end

      r_cpu_step <= w_pop && (r_state == ST_IDLE) && (r_data == CMD_STEP);

      if (w_pop && r_state == ST_IDLE && r_data == CMD_RUN) begin
        r_cpu_run <= 1'b1;
      end else if (r_state == ST_RUN && w_next == ST_SEND) begin
        r_cpu_run <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX serializer
  // ---------------------------------------------------------------------------
  tx_byte_seq u_tx (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_tx_load),
    .i_bytes   (w_tx_bytes),
    .i_count   (w_tx_cnt),
    .i_tx_full (tx_full),
    .o_w_data  (w_data),
    .o_wr_uart (wr_uart),
    .o_busy    (w_tx_busy),
    .o_done    (w_tx_done)
  );

  // Pop strobe is combinational with rx_empty; gate it so reset forces it low.
  assign rd_uart    = w_pop & ~reset & ~w_tx_busy;
  assign imem_we    = (r_state == ST_WRITE);
  assign imem_addr  = r_addr;
  assign imem_wdata = r_word;
  assign cpu_run    = r_cpu_run;
  assign cpu_step   = r_cpu_step;
  assign dbg_sel    = r_dbg_sel;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
module tb_uart_loader_ctrl;

  logic        clk;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        cpu_step;
  logic        cpu_halted;
  logic [7:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic [2:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int drv_err = 0;
  int cyc     = 0;
  int last_tx_cyc = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  tx_got[$];
  logic [9:0]  we_addr_q[$];
  logic [31:0] we_data_q[$];

  uart_loader_ctrl #(.ADDR_W(10), .TIMEOUT_CYC(100), .TO_W(23)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .r_data     (r_data),
    .rd_uart    (rd_uart),
    .tx_full    (tx_full),
    .w_data     (w_data),
    .wr_uart    (wr_uart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .cpu_step   (cpu_step),
    .cpu_halted (cpu_halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Debug-plane model: selector 5 returns a known word.
  assign dbg_data = (dbg_sel == 8'h05) ? 32'hA1B2C3D4 : 32'h0BAD_0BAD;

  // ---------------- monitors (sampled on the falling edge) ----------------
  always @(negedge clk) begin
    if (wr_uart) begin
      tx_got.push_back(w_data);
      last_tx_cyc = cyc;
    end
    if (imem_we) begin
      we_addr_q.push_back(imem_addr);
      we_data_q.push_back(imem_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    tx_got.delete();
    we_addr_q.delete();
    we_data_q.delete();
    drv_err = 0;
  endtask

  // Present one byte at the RX FIFO head until it is popped.
  task automatic push_rx(input logic [7:0] b);
    bit got;
    got = 1'b0;
    r_data   = b;
    rx_empty = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (rd_uart) got = 1'b1;
    end
    @(posedge clk);
    #1;
    rx_empty = 1'b1;
    if (!got) drv_err++;
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 300 && tx_got.size() < n; k++) begin
      @(negedge clk);
      #2;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; rx_empty = 1'b0; r_data = 8'h4C; tx_full = 1'b0; cpu_halted = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (rd_uart !== 1'b0) begin
      n_fail++; $display("FAIL reset_rd_uart: got %b want 0", rd_uart);
    end
    n_tests++;
    if ({wr_uart, imem_we, cpu_run, cpu_step, w_data, imem_addr, imem_wdata, dbg_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr=%b we=%b run=%b step=%b wd=%h addr=%h wdata=%h sel=%h want all 0",
               wr_uart, imem_we, cpu_run, cpu_step, w_data, imem_addr, imem_wdata, dbg_sel);
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    step();
    rx_empty = 1'b1;
    reset    = 1'b0;
    step();
  endtask

  task automatic test_load();
    logic [7:0] bytes [10];
    bytes = '{8'h4C, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    clear_sb();
    for (int i = 0; i < 10; i++) push_rx(bytes[i]);
    // Pop of the final byte happened at the last edge: write is this cycle.
    @(negedge clk);
    n_tests++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 10'd1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL load_latency_we: we=%b addr=%0d data=%h want 1/1/deadbeef", imem_we, imem_addr, imem_wdata);
    end
    step();
    @(negedge clk);
    n_tests++;
    if ({wr_uart, w_data} !== {1'b1, 8'h06}) begin
      n_fail++; $display("FAIL load_ack_latency: wr=%b data=%h want 1/06", wr_uart, w_data);
    end
    wait_tx(1);
    repeat (3) step();
    n_tests++;
    if (we_addr_q.size() != 2) begin
      n_fail++; $display("FAIL load_we_count: got %0d want 2", we_addr_q.size());
    end else begin
      n_tests++;
      if ({we_addr_q[0], we_data_q[0]} !== {10'd0, 32'h12345678}) begin
        n_fail++; $display("FAIL load_word0: addr=%0d data=%h want 0/12345678", we_addr_q[0], we_data_q[0]);
      end
      n_tests++;
      if ({we_addr_q[1], we_data_q[1]} !== {10'd1, 32'hDEADBEEF}) begin
        n_fail++; $display("FAIL load_word1: addr=%0d data=%h want 1/deadbeef", we_addr_q[1], we_data_q[1]);
      end
    end
    exp_q.push_back(8'h06);
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL load_tx: count=%0d first=%h want 1 byte 06", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00);
    end
    n_tests++;
    if (dbg_state !== 3'd0 || drv_err != 0) begin
      n_fail++; $display("FAIL load_end: state=%0d rx_stalls=%0d want 0/0", dbg_state, drv_err);
    end
  endtask

  task automatic test_backpressure();
    int viol;
    viol = 0;
    clear_sb();
    tx_full = 1'b1;
    push_rx(8'h53);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (wr_uart) viol++;
      step();
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++; $display("FAIL bp_hold: wr_uart high %0d cycles want 0", viol);
    end
    tx_full = 1'b0;
    wait_tx(1);
    repeat (5) step();
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== 8'h06) begin
      n_fail++; $display("FAIL bp_release: count=%0d first=%h want 1 byte 06", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00);
    end
  endtask

  task automatic test_run_halt();
    clear_sb();
    push_rx(8'h52);
    @(negedge clk);
    n_tests++;
    if ({cpu_run, dbg_state} !== {1'b1, 3'd7}) begin
      n_fail++; $display("FAIL run_start: run=%b state=%0d want 1/7", cpu_run, dbg_state);
    end
    push_rx(8'h11);  // ignored while running
    repeat (48) step();
    n_tests++;
    if (cpu_run !== 1'b1 || tx_got.size() != 0) begin
      n_fail++; $display("FAIL run_ignore: run=%b tx_count=%0d want 1/0", cpu_run, tx_got.size());
    end
    // CPU halt and a host 'H' in the same cycle: halt wins, 'H' stays queued.
    cpu_halted = 1'b1; r_data = 8'h48; rx_empty = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_uart !== 1'b0) begin
      n_fail++; $display("FAIL run_halt_priority: rd_uart=%b want 0", rd_uart);
    end
    step();
    cpu_halted = 1'b0; rx_empty = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cpu_run !== 1'b0) begin
      n_fail++; $display("FAIL run_halted_clear: run=%b want 0", cpu_run);
    end
    wait_tx(1);
    repeat (3) step();
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== 8'h68) begin
      n_fail++; $display("FAIL run_halted_tx: count=%0d first=%h want 1 byte 68", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00);
    end
    // Host halt
    clear_sb();
    push_rx(8'h52);
    repeat (10) step();
    push_rx(8'h48);
    @(negedge clk);
    n_tests++;
    if (cpu_run !== 1'b0) begin
      n_fail++; $display("FAIL run_host_halt: run=%b want 0", cpu_run);
    end
    wait_tx(1);
    repeat (3) step();
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== 8'h06 || drv_err != 0) begin
      n_fail++; $display("FAIL run_host_tx: count=%0d first=%h stalls=%0d want 1 byte 06", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00, drv_err);
    end
  endtask

  task automatic test_dump();
    clear_sb();
    exp_q.push_back(8'hD4); exp_q.push_back(8'hC3);
    exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
    push_rx(8'h44);
    push_rx(8'h05);
    @(negedge clk);
    n_tests++;
    if (dbg_sel !== 8'h05) begin
      n_fail++; $display("FAIL dump_sel: got %h want 05", dbg_sel);
    end
    wait_tx(4);
    repeat (3) step();
    n_tests++;
    if (tx_got.size() != 4) begin
      n_fail++; $display("FAIL dump_count: got %0d want 4", tx_got.size());
    end
    for (int i = 0; i < 4 && i < tx_got.size(); i++) begin
      n_tests++;
      if (tx_got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL dump_byte%0d: got %h want %h", i, tx_got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_unknown();
    clear_sb();
    push_rx(8'h7A);
    wait_tx(1);
    repeat (3) step();
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== 8'h15) begin
      n_fail++; $display("FAIL unknown_nak: count=%0d first=%h want 1 byte 15", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00);
    end
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL unknown_state: got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_sb();
    push_rx(8'h4C);
    push_rx(8'h03);
    push_rx(8'h11);
    rx_empty = 1'b0; r_data = 8'h22;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({rd_uart, wr_uart, imem_we, cpu_run, cpu_step, w_data, imem_addr, imem_wdata, dbg_sel, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_load: rd=%b wr=%b we=%b wdata=%h state=%0d want all 0",
               rd_uart, wr_uart, imem_we, imem_wdata, dbg_state);
    end
    rx_empty = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    clear_sb();
    push_rx(8'h53);
    @(negedge clk);
    n_tests++;
    if (cpu_step !== 1'b1) begin
      n_fail++; $display("FAIL step_pulse_hi: got %b want 1", cpu_step);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (cpu_step !== 1'b0) begin
      n_fail++; $display("FAIL step_pulse_lo: got %b want 0", cpu_step);
    end
    wait_tx(1);
    repeat (3) step();
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== 8'h06 || we_addr_q.size() != 0) begin
      n_fail++; $display("FAIL step_ack: count=%0d first=%h writes=%0d want 1 byte 06, 0 writes", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00, we_addr_q.size());
    end
  endtask

`ifdef UART_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    clear_sb();
    push_rx(8'h4C);
    push_rx(8'h01);
    push_rx(8'hAA);
    push_rx(8'hBB);
    t0 = cyc;
    wait_tx(1);
    repeat (3) step();
    n_tests++;
    if (tx_got.size() != 1 || tx_got[0] !== 8'h15) begin
      n_fail++; $display("FAIL timeout_nak: count=%0d first=%h want 1 byte 15", tx_got.size(), (tx_got.size() > 0) ? tx_got[0] : 8'h00);
    end
    n_tests++;
    if ((last_tx_cyc - t0) < 98 || (last_tx_cyc - t0) > 104) begin
      n_fail++; $display("FAIL timeout_delay: got %0d cycles want about 100", last_tx_cyc - t0);
    end
    n_tests++;
    if (we_addr_q.size() != 0 || dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL timeout_abort: writes=%0d state=%0d want 0/0", we_addr_q.size(), dbg_state);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1; rx_empty = 1'b1; r_data = 8'h00; tx_full = 1'b0; cpu_halted = 1'b0;
    test_reset();
    test_load();
    test_backpressure();
    test_run_halt();
    test_dump();
    test_unknown();
    test_reset_mid_load();
`ifdef UART_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
